s_ram_arbiter: RTL and testbench

- Round-robin arbiter sharing the single-port 256x8 s_RAM between the RC4 sub-FSMs: init, key-schedule swap and PRGA/decrypt.
- Grants exclusive, locked ownership to one requester at a time.
- Muxes the owner's address, data and wren onto the RAM.
- Tags returning read data back to the requester that issued the read.
- Sits between the top-level sequencer's sub-FSMs and the s_RAM instance.

---
 rtl/s_ram_arbiter.sv | 134 +++++++++++++
 tb/tb_s_ram_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_ram_arbiter.sv
// Round-robin, ownership-locked arbiter sharing the single-port RC4 s_RAM between
// the init, swap and decrypt sub-FSMs, with per-requester tagging of read data.
module s_ram_arbiter #(
  parameter int NREQ   = 3,
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]   req_wren,
  output logic [NREQ-1:0]   gnt,
  output logic [AW-1:0]     ram_address,
  output logic [DW-1:0]     ram_data,
  output logic              ram_wren,
  input  logic [DW-1:0]     ram_q,
  output logic [DW-1:0]     rd_data,
  output logic [NREQ-1:0]   rd_valid,
  output logic              busy,
  output logic              violation
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, GRANTED, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   owner, owner_nxt;
  logic [CW-1:0]   drain_cnt, drain_cnt_nxt;
  logic [NREQ-1:0] rd_tag_p [RD_LAT];
  logic [AW-1:0]   addr_hold;
  logic [DW-1:0]   data_hold;
  logic [AW-1:0]   own_addr;
  logic [DW-1:0]   own_data;
  logic            own_req, own_wren, rd_issue, granted, found;
  logic [PW-1:0]   winner;

  // First requesting index after 'last', wrapping modulo NREQ; MSB flags a hit.
  function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] last);
    logic [PW:0] res;
    int          idx;
    res = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (r[idx]) res = {1'b1, idx[PW-1:0]};
    end
    return res;
  endfunction

  assign {found, winner} = rr_pick(req, owner);
  assign granted  = (state == GRANTED);
  assign own_req  = req[owner];
  assign own_wren = req_wren[owner];
  assign own_addr = req_addr[owner*AW +: AW];
  assign own_data = req_data[owner*DW +: DW];
  assign rd_issue = granted & own_req & ~own_wren;

  assign ram_wren    = granted & own_req & own_wren;
  assign ram_address = granted ? own_addr : addr_hold;
  assign ram_data    = granted ? own_data : data_hold;
  assign rd_data     = ram_q;
  assign rd_valid    = rd_tag_p[RD_LAT-1];
  assign busy        = (state != IDLE);

  // 'owner' doubles as the round-robin pointer once ownership is released.
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    drain_cnt_nxt = drain_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANTED;
          owner_nxt = winner;
        end
      end
      GRANTED: begin
        if (!own_req) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = CW'(RD_LAT - 1);
        end
      end
      DRAIN: begin
        if (drain_cnt != '0) begin
          drain_cnt_nxt = drain_cnt - CW'(1);
        end else if (found) begin
          state_nxt = GRANTED;
          owner_nxt = winner;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      owner     <= PW'(NREQ - 1);
      drain_cnt <= '0;
      gnt       <= '0;
      violation <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      drain_cnt <= drain_cnt_nxt;
      gnt       <= (state_nxt == GRANTED) ? (NREQ'(1) << owner_nxt) : '0;
      violation <= violation | (|(req_wren & ~gnt));
    end
  end

  // Read-tag pipeline: advances every clock so reads finish during DRAIN.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) rd_tag_p[i] <= '0;
    end else begin
      rd_tag_p[0] <= rd_issue ? (NREQ'(1) << owner) : '0;
      for (int i = 1; i < RD_LAT; i++) rd_tag_p[i] <= rd_tag_p[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (granted) begin
      addr_hold <= own_addr;
      data_hold <= own_data;
    end
  end

endmodule

// File: tb/tb_s_ram_arbiter.sv
// Directed bench for s_ram_arbiter: a queue-based ownership/read model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_s_ram_arbiter;
  localparam int NREQ = 3, AW = 8, DW = 8, RD_LAT = 1;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   wren = '0;
  logic [7:0]        a [NREQ];
  logic [7:0]        d [NREQ];
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   gnt, rd_valid;
  logic [AW-1:0]     ram_address;
  logic [DW-1:0]     ram_data, rd_data;
  logic [DW-1:0]     ram_q = '0;
  logic              ram_wren, busy, violation;
  logic [7:0]        mem [256];

  int tests = 0;
  int fails = 0;

  assign req_addr = {a[2], a[1], a[0]};
  assign req_data = {d[2], d[1], d[0]};

  always #5 clock = ~clock;

  s_ram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_addr(req_addr),
    .req_data(req_data), .req_wren(wren), .gnt(gnt), .ram_address(ram_address),
    .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .violation(violation)
  );

  // Environment RAM with one clock of read latency.
  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  // Behavioural model: who owns the RAM, dead cycles left, pending tagged reads.
  typedef struct { int due; int id; logic [7:0] dat; } rd_t;
  rd_t        pend[$];
  int         m_owner = -1, m_ptr = NREQ - 1, m_drain = 0, cyc = 0;
  bit         m_viol = 0, hold_known = 0;
  logic [7:0] m_ha, m_hd;
  logic [7:0] m_mem [256];

  always @(negedge clock) begin
    logic [2:0] eg, erv;
    logic       ebusy, ew;
    logic [7:0] edat;
    int         w, c;
    if (!reset_n) begin
      pend.delete();
      m_owner = -1; m_ptr = NREQ - 1; m_drain = 0; m_viol = 0;
      chk("reset_outputs", {gnt, rd_valid, busy, violation}, 32'd0);
    end else begin
      eg    = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
      ebusy = (m_owner >= 0) || (m_drain > 0);
      ew    = (m_owner >= 0) && req[m_owner] && wren[m_owner];
      erv = '0; edat = '0;
      foreach (pend[j]) if (pend[j].due == cyc) begin
        erv[pend[j].id] = 1'b1;
        edat = pend[j].dat;
      end
      chk("gnt", gnt, eg);
      chk("busy", busy, ebusy);
      chk("ram_wren", ram_wren, ew);
      chk("violation", violation, m_viol);
      chk("rd_valid", rd_valid, erv);
      if (erv != 0) chk("rd_data", rd_data, edat);
      if (m_owner >= 0) begin
        chk("ram_address", ram_address, a[m_owner]);
        chk("ram_data", ram_data, d[m_owner]);
      end else if (hold_known) begin
        chk("ram_address_hold", ram_address, m_ha);
        chk("ram_data_hold", ram_data, m_hd);
      end
      while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
      if (|(wren & ~eg)) m_viol = 1;
      if (m_owner >= 0) begin
        if (req[m_owner] && !wren[m_owner])
          pend.push_back('{cyc + RD_LAT, m_owner, m_mem[a[m_owner]]});
        if (ew) m_mem[a[m_owner]] = d[m_owner];
        m_ha = a[m_owner]; m_hd = d[m_owner]; hold_known = 1;
        if (!req[m_owner]) begin
          m_owner = -1;
          m_drain = RD_LAT;
        end
      end else if (m_drain > 1) begin
        m_drain--;
      end else begin
        m_drain = 0;
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
          c = (m_ptr + k) % NREQ;
          if (w < 0 && req[c]) w = c;
        end
        if (w >= 0) begin
          m_owner = w;
          m_ptr = w;
        end
      end
    end
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'h00;
      m_mem[i] = 8'h00;
    end
    for (int i = 0; i < NREQ; i++) begin
      a[i] = 8'h00;
      d[i] = 8'h00;
    end
    repeat (2) tick();
    chk("reset_gnt", gnt, 3'b000);
    reset_n = 1'b1;

    // Requester 0 fills the RAM with s[i] = i.
    req = 3'b001;
    tick();
    chk("first_gnt", gnt, 3'b001);
    for (int i = 0; i < 300; i++) begin
      a[0] = 8'(i);
      d[0] = 8'(i);
      wren[0] = 1'b1;
      tick();
    end
    wren[0] = 1'b0;
    a[0] = 8'h2A;
    tick();
    tick();
    chk("readback_vld", rd_valid, 3'b001);
    chk("readback_data", rd_data, 8'h2A);
    chk("ram_s200", mem[200], 8'd200);
    chk("no_violation", violation, 1'b0);
    req = 3'b000;
    repeat (2) tick();

    // Requester 1 reads 0x10 then 0x11.
    req = 3'b010;
    a[1] = 8'h10;
    tick();
    chk("req1_gnt", gnt, 3'b010);
    tick();
    chk("rd10_vld", rd_valid, 3'b010);
    chk("rd10_data", rd_data, 8'h10);
    a[1] = 8'h11;
    tick();
    chk("rd11_vld", rd_valid, 3'b010);
    chk("rd11_data", rd_data, 8'h11);
    req = 3'b000;
    repeat (2) tick();

    // All three request together; each keeps ownership for 4 cycles.
    do_reset();
    req = 3'b111;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("rr_order", gnt, 3'b001 << k);
      repeat (3) tick();
      req[k] = 1'b0;
      tick();
      chk("dead_cycle", gnt, 3'b000);
      if (k == 2) req = 3'b101;
      tick();
    end
    chk("wrap_to_0", gnt, 3'b001);
    req[0] = 1'b0;
    repeat (2) tick();
    chk("reraised_2_next", gnt, 3'b100);
    req = 3'b000;
    repeat (2) tick();

    // Owner 2 reads in its last cycle, then hands over to requester 1.
    do_reset();
    req = 3'b100;
    a[2] = 8'h44;
    tick();
    chk("own2_gnt", gnt, 3'b100);
    tick();
    req = 3'b010;
    chk("tail_read_vld", rd_valid, 3'b100);
    chk("tail_read_data", rd_data, 8'h44);
    tick();
    chk("handover_dead", gnt, 3'b000);
    chk("handover_no_vld", rd_valid, 3'b000);
    tick();
    chk("handover_gnt", gnt, 3'b010);
    req = 3'b000;
    repeat (2) tick();

    // Ungranted write from requester 1.
    a[1] = 8'h05;
    d[1] = 8'hEE;
    wren[1] = 1'b1;
    #1;
    chk("ungranted_wren", ram_wren, 1'b0);
    chk("viol_before", violation, 1'b0);
    tick();
    chk("viol_set", violation, 1'b1);
    wren[1] = 1'b0;
    repeat (3) tick();
    chk("viol_sticky", violation, 1'b1);
    chk("ram_s5_intact", mem[5], 8'h05);

    // Async reset mid-grant with a read in flight.
    req = 3'b001;
    a[0] = 8'h20;
    tick();
    chk("pre_reset_gnt", gnt, 3'b001);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_gnt", gnt, 3'b000);
    chk("async_busy", busy, 1'b0);
    chk("async_rdv", rd_valid, 3'b000);
    chk("async_viol", violation, 1'b0);
    tick();
    chk("inflight_dropped", rd_valid, 3'b000);
    reset_n = 1'b1;
    req = 3'b111;
    tick();
    chk("post_reset_gnt", gnt, 3'b001);
    req = 3'b000;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
